// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types, constants and round-robin helper for the PRBS arbiter
// Purpose: FSM state encoding, default feedback polynomial and the
//          round-robin pick function used by prbs_arbiter.
// Contents: state_t (IDLE, SHIFT, DONE), POLY_DEFAULT, rr_pick().
package prbs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [8:0] POLY_DEFAULT = 9'h11D;

   // Returns the first set request at or after ptr, wrapping at n.
   // Requests are zero-extended to 16 bits so one function serves every N_REQ.
   function automatic logic [3:0] rr_pick(input logic [15:0] reqs,
                                          input logic [4:0]  ptr,
                                          input logic [4:0]  n);
      logic [3:0] pick;
      logic       found;
      logic [4:0] idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = ptr + 5'(i);
         // ptr < n and i < n, so one subtraction is enough to wrap
         if (idx >= n) idx = idx - n;
         if (!found && (5'(i) < n) && reqs[idx[3:0]]) begin
            pick  = idx[3:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - seedable Galois LFSR
// Purpose: right-shifting Galois LFSR; out is the current LSB.
// Ports: clk, arst (sync, active-high, state -> 1), en (advance one step),
//        load (load seed, priority over en), seed [W-1:0],
//        out (state[0]), state [W-1:0] (for zero-state detection).
module lfsr_core #(
   parameter int         W    = 8,
   parameter logic [W-1:0] TAPS = 8'h8E
) (
   input  logic         clk,
   input  logic         arst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] seed,
   output logic         out,
   output logic [W-1:0] state
);

   logic [W-1:0] state_q;

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q <= W'(1);
      end else if (load) begin
         state_q <= seed;
      end else if (en) begin
         state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      end
   end

   assign out   = state_q[0];
   assign state = state_q;

endmodule

// File: rtl/prbs_arbiter.sv
// rtl/prbs_arbiter.sv - round-robin arbiter sharing one Galois LFSR between requesters
// Purpose: grants requesters round-robin, clocks the LFSR WORD times for the
//          winner and delivers the assembled word with a one-cycle ack.
// Ports: clk, arst (sync, active-high), req [N_REQ-1:0], seed_load, seed [W-1:0],
//        ack [N_REQ-1:0] (one-hot pulse), valid, data [WORD-1:0],
//        gnt_id [$clog2(N_REQ)-1:0], busy (SHIFT/DONE),
//        lockup (sticky, only when PRBS_ARB_LOCKUP_EN is defined).
// Option: PRBS_ARB_LOCKUP_EN enables all-zero LFSR recovery and the lockup flag.
module prbs_arbiter
   import prbs_pkg::*;
#(
   parameter int         W     = 8,
   parameter logic [W:0] POLY  = POLY_DEFAULT,
   parameter int         N_REQ = 4,
   parameter int         WORD  = 8
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic [N_REQ-1:0]         req,
   input  logic                     seed_load,
   input  logic [W-1:0]             seed,
   output logic [N_REQ-1:0]         ack,
   output logic                     valid,
   output logic [WORD-1:0]          data,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     busy
`ifdef PRBS_ARB_LOCKUP_EN
   ,output logic                    lockup
`endif
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = (WORD > 1) ? $clog2(WORD) : 1;
   localparam logic [W-1:0] TAPS = W'(POLY >> 1);

   state_t            st_q;
   logic [IDW-1:0]    ptr_q, id_q, gnt_q;
   logic [CW-1:0]     cnt_q;
   logic [WORD-1:0]   word_q, word_d, data_q;
   logic [N_REQ-1:0]  ack_q;
   logic              valid_q, busy_q;

   logic              lfsr_out;
   logic [W-1:0]      lfsr_state;
   logic              core_en, core_load;
   logic [W-1:0]      core_seed;
   logic [IDW-1:0]    pick;

   assign pick    = IDW'(rr_pick(16'(req), 5'(ptr_q), 5'(N_REQ)));
   assign core_en = (st_q == SHIFT);

`ifdef PRBS_ARB_LOCKUP_EN
   logic fix;
   logic lockup_q;
   // A seed load in IDLE wins over recovery; the seed itself may be nonzero.
   assign fix       = (lfsr_state == '0) &&
                      (((st_q == IDLE) && !seed_load) || (st_q == SHIFT));
   assign core_load = ((st_q == IDLE) && seed_load) || fix;
   assign core_seed = fix ? W'(1) : seed;

   always_ff @(posedge clk) begin
      if (arst) lockup_q <= 1'b0;
      else if (fix) lockup_q <= 1'b1;
   end
   assign lockup = lockup_q;
`else
   logic unused_state;
   assign core_load    = (st_q == IDLE) && seed_load;
   assign core_seed    = seed;
   assign unused_state = ^lfsr_state;
`endif

   lfsr_core #(.W(W), .TAPS(TAPS)) u_lfsr (
      .clk   (clk),
      .arst  (arst),
      .en    (core_en),
      .load  (core_load),
      .seed  (core_seed),
      .out   (lfsr_out),
      .state (lfsr_state)
   );

   // Word bits are captured LSB first; every bit is rewritten each grant.
   always_comb begin
      word_d         = word_q;
      word_d[cnt_q]  = lfsr_out;
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         st_q    <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ack_q   <= '0;
         valid_q <= 1'b0;
         case (st_q)
            IDLE: begin
               if (!seed_load && (|req)) begin
                  id_q   <= pick;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  st_q   <= SHIFT;
               end
            end
            SHIFT: begin
               word_q <= word_d;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == CW'(WORD - 1)) begin
                  // Outputs are registered so they are live during DONE.
                  data_q  <= word_d;
                  gnt_q   <= id_q;
                  ack_q   <= N_REQ'(1) << id_q;
                  valid_q <= 1'b1;
                  st_q    <= DONE;
               end
            end
            DONE: begin
               ptr_q  <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
               busy_q <= 1'b0;
               st_q   <= IDLE;
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign ack    = ack_q;
   assign valid  = valid_q;
   assign data   = data_q;
   assign gnt_id = gnt_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_prbs_arbiter.sv
// tb/tb_prbs_arbiter.sv - directed self-checking bench for prbs_arbiter
module tb_prbs_arbiter;

   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic [3:0] req = '0;
   logic       seed_load = 1'b0;
   logic [7:0] seed = '0;
   logic [3:0] ack;
   logic       valid;
   logic [7:0] data;
   logic [1:0] gnt_id;
   logic       busy;
`ifdef PRBS_ARB_LOCKUP_EN
   logic       lockup;
`endif

   int checks = 0;
   int failures = 0;

   prbs_arbiter dut (
      .clk       (clk),
      .arst      (arst),
      .req       (req),
      .seed_load (seed_load),
      .seed      (seed),
      .ack       (ack),
      .valid     (valid),
      .data      (data),
      .gnt_id    (gnt_id),
      .busy      (busy)
`ifdef PRBS_ARB_LOCKUP_EN
      ,.lockup   (lockup)
`endif
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      arst = 1'b1; req = '0; seed_load = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ack !== 4'b0)   begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt got=%0d exp=0", gnt_id); end
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef PRBS_ARB_LOCKUP_EN
      checks++; if (lockup !== 1'b0) begin failures++; $display("FAIL reset_lockup got=%b exp=0", lockup); end
`endif
      arst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_first_word();
      int n = 0;
      req = 4'b0001;
      while (!valid && n < 30) begin @(negedge clk); n++; end
      req = '0;
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL first_timeout got=%b exp=1", valid); end
      checks++; if (n != 9) begin failures++; $display("FAIL first_latency got=%0d exp=9", n); end
      checks++; if (data !== 8'h8D) begin failures++; $display("FAIL first_data got=%h exp=8d", data); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL first_gnt got=%0d exp=0", gnt_id); end
      checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL first_ack got=%b exp=0001", ack); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", busy); end
      checks++; if (dut.u_lfsr.state_q !== 8'h83) begin failures++; $display("FAIL first_state got=%h exp=83", dut.u_lfsr.state_q); end
      @(negedge clk);
      checks++; if (valid !== 1'b0 || ack !== 4'b0) begin failures++; $display("FAIL first_pulse got=%b/%b exp=0/0000", valid, ack); end
      checks++; if (data !== 8'h8D) begin failures++; $display("FAIL first_hold got=%h exp=8d", data); end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_gnt [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [1:0] g [5];
      logic [7:0] d [5];
      int         t [5];
      int         k = 0, c = 0;
      req = 4'b1111;
      while (k < 5 && c < 80) begin
         @(negedge clk); c++;
         if (valid) begin g[k] = gnt_id; d[k] = data; t[k] = c; k++; end
      end
      req = '0;
      checks++; if (k != 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", k); end
      for (int i = 0; i < k; i++) begin
         checks++; if (g[i] !== exp_gnt[i]) begin failures++; $display("FAIL rr_gnt%0d got=%0d exp=%0d", i, g[i], exp_gnt[i]); end
         if (i > 0) begin
            checks++; if (t[i] - t[i-1] != 10) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=10", i, t[i] - t[i-1]); end
         end
      end
      if (k >= 2) begin
         checks++; if (d[0] !== 8'h8D) begin failures++; $display("FAIL rr_data0 got=%h exp=8d", d[0]); end
         checks++; if (d[1] !== 8'h17) begin failures++; $display("FAIL rr_data1 got=%h exp=17", d[1]); end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_seed_priority();
      int n = 0;
      seed_load = 1'b1; seed = 8'h01; req = 4'b0100;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seedprio_nogrant got=%b exp=0", busy); end
      seed_load = 1'b0;
      while (!valid && n < 30) begin @(negedge clk); n++; end
      req = '0;
      checks++; if (n != 9) begin failures++; $display("FAIL seedprio_latency got=%0d exp=9", n); end
      checks++; if (gnt_id !== 2'd2) begin failures++; $display("FAIL seedprio_gnt got=%0d exp=2", gnt_id); end
      checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL seedprio_ack got=%b exp=0100", ack); end
      checks++; if (data !== 8'h8D) begin failures++; $display("FAIL seedprio_data got=%h exp=8d", data); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_withdraw();
      int n = 0, extra = 0;
      req = 4'b0010;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL withdraw_busy got=%b exp=1", busy); end
      req = '0;
      while (!valid && n < 30) begin @(negedge clk); n++; end
      checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL withdraw_ack got=%b exp=0010", ack); end
      checks++; if (gnt_id !== 2'd1) begin failures++; $display("FAIL withdraw_gnt got=%0d exp=1", gnt_id); end
      checks++; if (data !== 8'h17) begin failures++; $display("FAIL withdraw_data got=%h exp=17", data); end
      repeat (20) begin @(negedge clk); if (valid) extra++; end
      checks++; if (extra != 0) begin failures++; $display("FAIL withdraw_regrant got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid_shift();
      int n = 0;
      req = 4'b0001;
      repeat (4) @(negedge clk);
      arst = 1'b1; req = '0;
      @(negedge clk);
      checks++; if (ack !== 4'b0)   begin failures++; $display("FAIL rstmid_ack got=%b exp=0000", ack); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL rstmid_gnt got=%0d exp=0", gnt_id); end
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      arst = 1'b0;
      @(negedge clk);
      req = 4'b0001;
      while (!valid && n < 30) begin @(negedge clk); n++; end
      req = '0;
      checks++; if (data !== 8'h8D) begin failures++; $display("FAIL rstmid_next got=%h exp=8d", data); end
      checks++; if (n != 9) begin failures++; $display("FAIL rstmid_latency got=%0d exp=9", n); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_seed();
      logic [7:0] exp_word;
      int n;
`ifdef PRBS_ARB_LOCKUP_EN
      exp_word = 8'h8D;
`else
      exp_word = 8'h00;
`endif
      seed_load = 1'b1; seed = 8'h00;
      @(negedge clk);
      seed_load = 1'b0; req = 4'b1000;
      n = 0;
      while (!valid && n < 30) begin @(negedge clk); n++; end
      req = '0;
      checks++; if (gnt_id !== 2'd3) begin failures++; $display("FAIL zero_gnt0 got=%0d exp=3", gnt_id); end
      checks++; if (data !== exp_word) begin failures++; $display("FAIL zero_data0 got=%h exp=%h", data, exp_word); end
`ifdef PRBS_ARB_LOCKUP_EN
      checks++; if (lockup !== 1'b1) begin failures++; $display("FAIL zero_lockup got=%b exp=1", lockup); end
`endif
      repeat (2) @(negedge clk);
      req = 4'b0001;
      n = 0;
      while (!valid && n < 30) begin @(negedge clk); n++; end
      req = '0;
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL zero_gnt1 got=%0d exp=0", gnt_id); end
`ifdef PRBS_ARB_LOCKUP_EN
      checks++; if (data !== 8'h17) begin failures++; $display("FAIL zero_data1 got=%h exp=17", data); end
      checks++; if (lockup !== 1'b1) begin failures++; $display("FAIL zero_lockup_sticky got=%b exp=1", lockup); end
`else
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL zero_data1 got=%h exp=00", data); end
`endif
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_reset();
      test_round_robin();
      test_seed_priority();
      test_withdraw();
      test_reset_mid_shift();
      test_zero_seed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
